// File: rtl/gon_tag_scheduler_if.sv
// Tag-FIFO write side and monitored data-FIFO read side of the GON tag scheduler.
// The scheduler owns the master view; the FIFO pair (or a bench) owns the slave view.
interface gon_tag_scheduler_if #(
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4
);
   logic [ROW_TAG_WIDTH-1:0] row_tag;
   logic [COL_TAG_WIDTH-1:0] col_tag;
   logic                     tags_wr_en;
   logic                     tags_full;
   logic                     data_rd_en;
   logic                     data_empty;

   modport master (
      output row_tag, col_tag, tags_wr_en,
      input  tags_full, data_rd_en, data_empty
   );

   modport slave (
      input  row_tag, col_tag, tags_wr_en,
      output tags_full, data_rd_en, data_empty
   );
endinterface

// File: rtl/gon_tag_scheduler.sv
// GON tag scheduler: walks a configured row x column tag rectangle a programmed
// number of times, pushing one tag pair per cycle into the tags FIFO, then waits
// until every issued tag has been retired from the data FIFO before signalling done.
module gon_tag_scheduler #(
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     configure,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_start,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_end,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_start,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_end,
   input  logic [COUNT_WIDTH-1:0]   cfg_repeat,
   input  logic                     start,
   input  logic                     abort,
   gon_tag_scheduler_if.master      fifo,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   // Wide enough that rows*cols*repeat can never wrap, so the range check is exact.
   localparam int PROD_W = ROW_TAG_WIDTH + COL_TAG_WIDTH + COUNT_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   logic [ROW_TAG_WIDTH-1:0] row_start_q, row_end_q, row_q;
   logic [COL_TAG_WIDTH-1:0] col_start_q, col_end_q, col_q;
   logic [COUNT_WIDTH-1:0]   repeat_q, pass_q, retired_q, total_q;
   logic                     cfg_err_q;

   logic [PROD_W-1:0] rows_ext, cols_ext, repeat_ext, product;
   logic              cfg_valid;
   logic              push, retire;
   logic              col_last, row_last, pass_last, last_tag;

   // Size of the run implied by the registered configuration.
   assign rows_ext   = PROD_W'(row_end_q) - PROD_W'(row_start_q) + PROD_W'(1);
   assign cols_ext   = PROD_W'(col_end_q) - PROD_W'(col_start_q) + PROD_W'(1);
   assign repeat_ext = PROD_W'(repeat_q);
   assign product    = rows_ext * cols_ext * repeat_ext;

   // The total must fit the counters; ranges must be ordered and repeat non-zero.
   assign cfg_valid = (row_start_q <= row_end_q) && (col_start_q <= col_end_q) &&
                      (repeat_q != '0) && (product[PROD_W-1:COUNT_WIDTH] == '0);

   assign push   = (state_q == ST_ISSUE) && !fifo.tags_full;
   assign retire = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                   fifo.data_rd_en && !fifo.data_empty;

   assign col_last  = (col_q == col_end_q);
   assign row_last  = (row_q == row_end_q);
   assign pass_last = (pass_q == repeat_q - COUNT_WIDTH'(1));
   assign last_tag  = col_last && row_last && pass_last;

   assign fifo.tags_wr_en = push;
   assign fifo.row_tag    = row_q;
   assign fifo.col_tag    = col_q;
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);
   assign cfg_err         = cfg_err_q;

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort outranks a simultaneous push or retire.
   always_comb begin
      // NOTE: next state defaults to the current one before any branch, so no
      // path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start && cfg_valid) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (abort)                 state_d = ST_IDLE;
            else if (push && last_tag) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)                        state_d = ST_IDLE;
            else if (retired_q == total_q)    state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Configuration registers: loaded only while idle, kept across runs for reissue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_start_q <= '0;
         row_end_q   <= '0;
         col_start_q <= '0;
         col_end_q   <= '0;
         repeat_q    <= '0;
      end else if (configure && (state_q == ST_IDLE)) begin
         row_start_q <= cfg_row_start;
         row_end_q   <= cfg_row_end;
         col_start_q <= cfg_col_start;
         col_end_q   <= cfg_col_end;
         repeat_q    <= cfg_repeat;
      end
   end

   // Error pulse: configure while running, or start with an unusable configuration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cfg_err_q <= 1'b0;
      else        cfg_err_q <= (configure && (state_q != ST_IDLE)) ||
                               (start && (state_q == ST_IDLE) && !cfg_valid);
   end

   // Tag walk and run counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q     <= '0;
         col_q     <= '0;
         pass_q    <= '0;
         retired_q <= '0;
         total_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && cfg_valid) begin
                  row_q     <= row_start_q;
                  col_q     <= col_start_q;
                  pass_q    <= '0;
                  retired_q <= '0;
                  total_q   <= product[COUNT_WIDTH-1:0];
               end
            end
            ST_ISSUE, ST_DRAIN: begin
               if (abort) begin
                  pass_q    <= '0;
                  retired_q <= '0;
                  total_q   <= '0;
               end else begin
                  if (push) begin
                     if (col_last) begin
                        col_q <= col_start_q;
                        if (row_last) begin
                           row_q  <= row_start_q;
                           pass_q <= pass_q + COUNT_WIDTH'(1);
                        end else begin
                           row_q <= row_q + ROW_TAG_WIDTH'(1);
                        end
                     end else begin
                        col_q <= col_q + COL_TAG_WIDTH'(1);
                     end
                  end
                  if (retire) retired_q <= retired_q + COUNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gon_tag_scheduler.sv
// Scoreboard bench for gon_tag_scheduler: the driver expands each run into its
// expected tag list from the configured ranges; a negedge monitor pops and compares
// every push and checks done/cfg_err/idle expectations keyed by cycle number.
module tb_gon_tag_scheduler;
   localparam int RW = 4;
   localparam int CW = 4;
   localparam int NW = 16;

   typedef struct {
      int row;
      int col;
   } tag_t;

   logic          clk, reset;
   logic          configure, start, abort;
   logic [RW-1:0] cfg_row_start, cfg_row_end;
   logic [CW-1:0] cfg_col_start, cfg_col_end;
   logic [NW-1:0] cfg_repeat;
   logic          busy, done, cfg_err;

   gon_tag_scheduler_if #(.ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW)) fifo_if ();

   gon_tag_scheduler #(.ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
      .clk           (clk),
      .reset         (reset),
      .configure     (configure),
      .cfg_row_start (cfg_row_start),
      .cfg_row_end   (cfg_row_end),
      .cfg_col_start (cfg_col_start),
      .cfg_col_end   (cfg_col_end),
      .cfg_repeat    (cfg_repeat),
      .start         (start),
      .abort         (abort),
      .fifo          (fifo_if.master),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   int   vectors = 0;
   int   miscompares = 0;
   int   cycle_cnt = 0;
   tag_t exp_q[$];
   int   done_q[$], err_q[$], idle_q[$];
   bit   issue_active = 0, run_busy = 0, run_done = 0, full_used = 0;
   int   full_mode = 0, rd_mode = 0, full_left = 0;
   int   pushes_seen = 0, retires_seen = 0, cur_total = -1;
   int   m_rs = 0, m_re = 0, m_cs = 0, m_ce = 0, m_rep = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit cfg_ok();
      longint prod;
      prod = longint'(m_re - m_rs + 1) * longint'(m_ce - m_cs + 1) * longint'(m_rep);
      return (m_rs <= m_re) && (m_cs <= m_ce) && (m_rep != 0) && (prod < (longint'(1) << NW));
   endfunction

   // Tags FIFO back-pressure and data FIFO model (one data word per pushed tag).
   always @(posedge clk) begin
      #2;
      fifo_if.data_empty = (pushes_seen == retires_seen);
      case (rd_mode)
         1:       fifo_if.data_rd_en = 1'b1;
         2:       fifo_if.data_rd_en = 1'b0;
         default: fifo_if.data_rd_en = ($urandom_range(0, 3) != 0);
      endcase
      case (full_mode)
         1: fifo_if.tags_full = ($urandom_range(0, 2) == 0);
         2: begin
            if (!full_used && pushes_seen == 2) begin
               full_left = 3;
               full_used = 1;
            end
            fifo_if.tags_full = (full_left > 0);
            if (full_left > 0) full_left--;
         end
         default: fifo_if.tags_full = 1'b0;
      endcase
   end

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      tag_t t;
      bit   exp_wr, exp_d, exp_e;
      if (reset) begin
         exp_wr = issue_active && (exp_q.size() > 0) && !fifo_if.tags_full;
         check("tags_wr_en", fifo_if.tags_wr_en, exp_wr);
         if (fifo_if.tags_wr_en && exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check("row_tag", fifo_if.row_tag, t.row);
            check("col_tag", fifo_if.col_tag, t.col);
            pushes_seen++;
         end
         if (fifo_if.data_rd_en && !fifo_if.data_empty) begin
            retires_seen++;
            if (retires_seen == cur_total) done_q.push_back(cycle_cnt + 2);
         end
         exp_d = (done_q.size() > 0) && (done_q[0] == cycle_cnt);
         if (exp_d) void'(done_q.pop_front());
         check("done", done, exp_d);
         if (done) run_done = 1;
         exp_e = (err_q.size() > 0) && (err_q[0] == cycle_cnt);
         if (exp_e) void'(err_q.pop_front());
         check("cfg_err", cfg_err, exp_e);
         if (idle_q.size() > 0 && idle_q[0] == cycle_cnt) begin
            void'(idle_q.pop_front());
            check("idle_busy", busy, 1'b0);
            check("idle_wr_en", fifo_if.tags_wr_en, 1'b0);
         end
      end
   end

   task automatic clear_run();
      exp_q.delete();
      done_q.delete();
      issue_active = 0;
      run_busy     = 0;
      pushes_seen  = 0;
      retires_seen = 0;
      cur_total    = -1;
   endtask

   task automatic clear_bench();
      clear_run();
      err_q.delete();
      idle_q.delete();
      run_done  = 0;
      full_mode = 0;
      rd_mode   = 0;
      m_rs = 0; m_re = 0; m_cs = 0; m_ce = 0; m_rep = 0;
   endtask

   task automatic hard_reset();
      reset = 1'b0;
      clear_bench();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic do_configure(input int rs, input int re, input int cs, input int ce, input int rep);
      cfg_row_start = RW'(rs);
      cfg_row_end   = RW'(re);
      cfg_col_start = CW'(cs);
      cfg_col_end   = CW'(ce);
      cfg_repeat    = NW'(rep);
      configure     = 1'b1;
      if (run_busy) err_q.push_back(cycle_cnt + 1);
      else begin
         m_rs = rs; m_re = re; m_cs = cs; m_ce = ce; m_rep = rep;
      end
      tick();
      configure = 1'b0;
   endtask

   task automatic do_start();
      bit ok;
      ok = !run_busy && cfg_ok();
      start = 1'b1;
      if (!run_busy && !ok) err_q.push_back(cycle_cnt + 1);
      if (ok) begin
         clear_run();
         for (int p = 0; p < m_rep; p++)
            for (int r = m_rs; r <= m_re; r++)
               for (int c = m_cs; c <= m_ce; c++)
                  exp_q.push_back('{row: r, col: c});
         cur_total = exp_q.size();
         run_busy  = 1;
         run_done  = 0;
      end
      tick();
      start = 1'b0;
      if (ok) issue_active = 1;
   endtask

   task automatic run(input int rs, input int re, input int cs, input int ce, input int rep,
                      input bit cfg, input int fmode, input int rmode, input int abort_at,
                      input bit junk);
      int n;
      full_mode = fmode;
      full_used = 0;
      full_left = 0;
      rd_mode   = rmode;
      if (cfg) do_configure(rs, re, cs, ce, rep);
      do_start();
      if (!run_busy) begin
         idle_q.push_back(cycle_cnt);
         idle_q.push_back(cycle_cnt + 1);
         tick(); tick(); tick();
         return;
      end
      n = 1;
      while (!run_done && n < 3000) begin
         if (n == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            clear_run();
            idle_q.push_back(cycle_cnt);
            tick(); tick();
            return;
         end
         if (junk && n == 1) begin
            start = 1'b1;
            do_configure(0, 15, 0, 15, 1);
            start = 1'b0;
         end else begin
            tick();
         end
         n++;
      end
      check("run_done", run_done, 1'b1);
      if (!run_done) begin
         hard_reset();
         return;
      end
      check("tags_left", exp_q.size(), 0);
      idle_q.push_back(cycle_cnt);
      clear_run();
      tick();
   endtask

   task automatic reset_in_drain();
      full_mode = 0;
      rd_mode   = 2;
      do_configure(2, 3, 5, 6, 1);
      do_start();
      for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick();
      tick(); tick();
      check("drain_busy", busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_row_tag", fifo_if.row_tag, 0);
      check("rst_col_tag", fifo_if.col_tag, 0);
      check("rst_wr_en", fifo_if.tags_wr_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cfg_err", cfg_err, 1'b0);
      clear_bench();
      tick(); tick();
      reset = 1'b1;
      tick();
      idle_q.push_back(cycle_cnt);
      do_start();
      idle_q.push_back(cycle_cnt);
      tick(); tick();
   endtask

   initial begin
      reset = 1'b1;
      configure = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_row_start = '0; cfg_row_end = '0; cfg_col_start = '0; cfg_col_end = '0;
      cfg_repeat = '0;
      fifo_if.tags_full = 1'b0; fifo_if.data_rd_en = 1'b0; fifo_if.data_empty = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("por_row_tag", fifo_if.row_tag, 0);
      check("por_col_tag", fifo_if.col_tag, 0);
      check("por_wr_en", fifo_if.tags_wr_en, 1'b0);
      check("por_busy", busy, 1'b0);
      check("por_done", done, 1'b0);
      check("por_cfg_err", cfg_err, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      tick();

      // Start straight out of reset: repeat is zero.
      idle_q.push_back(cycle_cnt);
      do_start();
      idle_q.push_back(cycle_cnt);
      tick(); tick();

      run(2, 3, 5, 6, 1, 1, 0, 1, 0, 0);     // basic 2x2 walk, read every cycle
      run(2, 3, 5, 6, 1, 1, 2, 1, 0, 0);     // back-pressure after the 2nd push
      run(1, 1, 1, 1, 3, 1, 0, 1, 0, 0);     // single tag, three passes
      run(5, 2, 0, 0, 1, 1, 0, 0, 0, 0);     // reversed row range
      run(3, 3, 9, 4, 1, 1, 0, 0, 0, 0);     // reversed column range
      run(0, 15, 0, 15, 256, 1, 0, 0, 0, 0); // total exactly 2^16: too large
      run(4, 4, 4, 4, 0, 1, 0, 0, 0, 0);     // zero repeat
      run(0, 15, 0, 15, 3, 1, 1, 0, 0, 1);   // full range, random stalls, junk mid-run
      run(2, 3, 5, 6, 2, 1, 0, 1, 2, 0);     // abort in the 2nd ISSUE cycle
      run(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);     // reissue of retained config
      run(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);     // reissue again with stalls
      reset_in_drain();

      for (int i = 0; i < 40; i++) begin
         int rs, re, cs, ce, rep, ab, tot;
         bit jk;
         rs  = $urandom_range(0, 15);
         re  = rs + $urandom_range(0, 3);
         if (re > 15) re = 15;
         cs  = $urandom_range(0, 15);
         ce  = cs + $urandom_range(0, 3);
         if (ce > 15) ce = 15;
         rep = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
         if ($urandom_range(0, 9) == 0 && re < 15) begin
            int tmp;
            tmp = rs; rs = re + 1; re = tmp;
         end
         tot = (rs <= re && cs <= ce) ? (re - rs + 1) * (ce - cs + 1) * rep : 0;
         ab  = (tot >= 6 && $urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
         jk  = (ab == 0) && ($urandom_range(0, 2) == 0);
         run(rs, re, cs, ce, rep, 1, 1, 0, ab, jk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
